byte_stacker: RTL and testbench

Packs a stream of 32-bit words into 128-bit blocks, the inverse of the 128-to-32 unstacking path. It sits on the AES datapath egress side, gathering four 32-bit streamer words into one 128-bit block for the cipher core or for writeback. Optional early termination zero-pads a short final block. Both sides use valid/ready handshakes, and the output is held until it is accepted.

---
 rtl/byte_stacker.sv | 83 ++++++++
 tb/tb_byte_stacker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_stacker.sv
// Gathers four 32-bit words into one 128-bit block, first word in the MSBs.
// last_i closes a block early with zero padding; a second block can park while the output is held.
module byte_stacker (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         enable_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [31:0]  word_i,
  input  logic         last_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] word_o,
  output logic         last_o
);

  logic [127:0] stack_r;
  logic [1:0]   cnt_r;
  logic         full_r;
  logic         lastpend_r;

  logic [127:0] stack_wr;
  logic [127:0] block;
  logic         accept;
  logic         take;
  logic         closing;
  logic         out_free;

  assign ready_o  = enable_i & ~full_r;
  assign accept   = valid_i & ready_o;
  assign take     = valid_o & ready_i;
  assign out_free = ~valid_o | take;
  assign closing  = accept & ((cnt_r == 2'd3) | last_i);

  // Lanes above the incoming word are forced to zero so a short block is padded.
  always_comb begin
    stack_wr = stack_r;
    block    = '0;
    for (int k = 0; k < 4; k++) begin
      if (2'(k) == cnt_r) stack_wr[127-32*k -: 32] = word_i;
      if (2'(k) <= cnt_r) block[127-32*k -: 32] = stack_wr[127-32*k -: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      stack_r    <= '0;
      cnt_r      <= '0;
      full_r     <= 1'b0;
      lastpend_r <= 1'b0;
      word_o     <= '0;
      last_o     <= 1'b0;
      valid_o    <= 1'b0;
    end else if (enable_i && full_r && out_free) begin
      // Parked block moves out; no accept can coincide because ready_o is low.
      word_o     <= stack_r;
      last_o     <= lastpend_r;
      valid_o    <= 1'b1;
      full_r     <= 1'b0;
      lastpend_r <= 1'b0;
      stack_r    <= '0;
    end else if (closing && out_free) begin
      word_o  <= block;
      last_o  <= last_i;
      valid_o <= 1'b1;
      cnt_r   <= '0;
      stack_r <= '0;
    end else begin
      if (take) valid_o <= 1'b0;
      if (closing) begin
        stack_r    <= block;
        full_r     <= 1'b1;
        lastpend_r <= last_i;
        cnt_r      <= '0;
      end else if (accept) begin
        stack_r <= stack_wr;
        cnt_r   <= cnt_r + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_byte_stacker.sv
// Scoreboard bench for byte_stacker: directed scenarios plus random traffic,
// checked against a queue-based block model and a block-occupancy model.
module tb_byte_stacker;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         clr_i = 1'b0;
  logic         enable_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [31:0]  word_i = '0;
  logic         last_i = 1'b0;
  logic         valid_o;
  logic         ready_i = 1'b0;
  logic [127:0] word_o;
  logic         last_o;

  int vectors = 0;
  int miscompares = 0;

  logic [128:0] exp_q[$];
  logic [31:0]  cur_q[$];
  bit           m_out = 1'b0;
  bit           m_park = 1'b0;

  byte_stacker dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .enable_i(enable_i),
    .valid_i(valid_i), .ready_o(ready_o), .word_i(word_i), .last_i(last_i),
    .valid_o(valid_o), .ready_i(ready_i), .word_o(word_o), .last_o(last_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor and reference model, evaluated mid-cycle where inputs are stable.
  always @(negedge clk_i) begin
    bit tk, acc, closing, free;
    logic [127:0] blk;
    logic [128:0] e;
    if (rst_i || clr_i) begin
      exp_q.delete();
      cur_q.delete();
      m_out  = 1'b0;
      m_park = 1'b0;
    end else begin
      tk  = valid_o & ready_i;
      acc = valid_i & ready_o;
      chk("ready_o", 128'(ready_o), 128'(enable_i & ~m_park));
      chk("valid_o", 128'(valid_o), 128'(m_out));
      if (tk) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_block", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("word_o", word_o, e[127:0]);
          chk("last_o", 128'(last_o), 128'(e[128]));
        end
      end
      closing = 1'b0;
      if (acc) begin
        cur_q.push_back(word_i);
        if (last_i || cur_q.size() == 4) begin
          blk = '0;
          for (int i = 0; i < cur_q.size(); i++) blk[127-32*i -: 32] = cur_q[i];
          exp_q.push_back({last_i, blk});
          cur_q.delete();
          closing = 1'b1;
        end
      end
      free = !m_out || tk;
      if (enable_i && m_park && free) begin
        m_park = 1'b0;
        m_out  = 1'b1;
      end else if (closing && free) begin
        m_out = 1'b1;
      end else begin
        if (tk) m_out = 1'b0;
        if (closing) m_park = 1'b1;
      end
    end
  end

  // Holds the word on the inputs until accepted; leaves valid_i high on return.
  task automatic send(input logic [31:0] w, input logic l, output int tries);
    bit ok;
    valid_i = 1'b1;
    word_i  = w;
    last_i  = l;
    tries   = 0;
    ok      = 1'b0;
    while (!ok && tries < 200) begin
      @(negedge clk_i);
      ok = ready_o;
      @(posedge clk_i);
      #1;
      tries++;
    end
    if (!ok) chk("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    last_i  = 1'b0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int t;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid_o", 128'(valid_o), 128'(0));
    chk("rst_word_o", word_o, 128'(0));
    chk("rst_ready_o", 128'(ready_o), 128'(1));
    rst_i = 1'b0;

    // four words back to back
    ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0, t);
    valid_i = 1'b0;
    chk("t1_valid", 128'(valid_o), 128'(1));
    chk("t1_word", word_o, 128'h00000001_00000002_00000003_00000004);
    chk("t1_last", 128'(last_o), 128'(0));
    idle(2);

    // sustained stream of 12 words
    for (int i = 0; i < 12; i++) begin
      send(32'h5000_0000 + 32'(i), 1'b0, t);
      chk("t2_one_cycle", 128'(t), 128'(1));
    end
    idle(3);
    chk("t2_drained", 128'(exp_q.size()), 128'(0));

    // two blocks against a stalled output
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), 1'b0, t);
    valid_i = 1'b0;
    chk("t3_ready_parked", 128'(ready_o), 128'(0));
    chk("t3_word_b1", word_o, 128'h00000100_00000101_00000102_00000103);
    idle(2);
    chk("t3_still_b1", word_o, 128'h00000100_00000101_00000102_00000103);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("t3_word_b2", word_o, 128'h00000104_00000105_00000106_00000107);
    chk("t3_valid_b2", 128'(valid_o), 128'(1));
    chk("t3_ready_back", 128'(ready_o), 128'(1));
    idle(2);

    // early termination with padding
    send(32'hAAAAAAAA, 1'b0, t);
    send(32'hBBBBBBBB, 1'b1, t);
    valid_i = 1'b0;
    last_i  = 1'b0;
    chk("t4_word", word_o, 128'hAAAAAAAA_BBBBBBBB_00000000_00000000);
    chk("t4_last", 128'(last_o), 128'(1));
    for (int i = 0; i < 4; i++) send(32'hD0 + 32'(i), 1'b0, t);
    valid_i = 1'b0;
    chk("t4_next_lane0", word_o, 128'h000000D0_000000D1_000000D2_000000D3);
    chk("t4_next_last", 128'(last_o), 128'(0));
    idle(2);

    // soft clear mid-block, then reset with a pending output
    send(32'hDEAD0001, 1'b0, t);
    send(32'hDEAD0002, 1'b0, t);
    valid_i = 1'b0;
    clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'h11 * 32'(i), 1'b0, t);
    valid_i = 1'b0;
    chk("t5_post_clear", word_o, 128'h00000011_00000022_00000033_00000044);
    idle(2);
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(32'hE0 + 32'(i), 1'b0, t);
    valid_i = 1'b0;
    chk("t5_valid_before_rst", 128'(valid_o), 128'(1));
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("t5_rst_valid", 128'(valid_o), 128'(0));
    chk("t5_rst_word", word_o, 128'(0));
    ready_i = 1'b1;
    idle(1);

    // enable low stalls input but keeps the partial block
    send(32'hC1, 1'b0, t);
    send(32'hC2, 1'b0, t);
    enable_i = 1'b0;
    word_i   = 32'hC3;
    repeat (3) begin
      @(negedge clk_i);
      chk("t6_ready_off", 128'(ready_o), 128'(0));
      @(posedge clk_i);
      #1;
    end
    enable_i = 1'b1;
    send(32'hC3, 1'b0, t);
    send(32'hC4, 1'b0, t);
    valid_i = 1'b0;
    chk("t6_word", word_o, 128'h000000C1_000000C2_000000C3_000000C4);
    idle(2);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      valid_i  = ($urandom_range(0, 9) < 7);
      word_i   = $urandom;
      last_i   = ($urandom_range(0, 9) == 0);
      ready_i  = ($urandom_range(0, 9) < 6);
      enable_i = ($urandom_range(0, 9) != 0);
      clr_i    = ($urandom_range(0, 99) < 2);
      @(posedge clk_i);
      #1;
    end
    clr_i    = 1'b0;
    enable_i = 1'b1;
    ready_i  = 1'b1;
    idle(6);
    chk("rand_drained", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
